booth_mul: RTL



---
 rtl/booth_mul.sv | 109 ++++++++++
 1 files changed

// File: rtl/booth_mul.sv
// booth_mul: sequential radix-4 Booth multiplier for signed two's-complement operands.
//   One Booth digit is retired per clock. The product is registered and held until
//   the next operation completes.
// Ports:
//   clk     in   rising-edge clock
//   resetn  in   asynchronous active-low reset
//   enable  in   start request, sampled only in IDLE
//   A       in   W-bit signed multiplicand
//   B       in   W-bit signed multiplier
//   P       out  2W-bit signed product (registered)
//   busy    out  high in RUN and DONE
//   done    out  one-cycle pulse when P has just been updated
module booth_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           enable,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] P,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(W/2);
    localparam logic [CW-1:0] LAST = CW'(W/2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W:0]      mplier_q, mplier_d;   // B with the guard bit appended below the LSB
    logic [2*W+1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  p_q, p_d;

    logic [W+1:0]    a_ext;
    logic [W+1:0]    pp;
    logic [2*W+1:0]  addend;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;

        // Partial product digit*A; two extra bits keep +-2A from overflowing.
        a_ext = {{2{mcand_q[W-1]}}, mcand_q};
        case (mplier_q[2:0])
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        // Sign-extend to accumulator width and place at weight 4^cnt.
        addend = {{W{pp[W+1]}}, pp} << {cnt_q, 1'b0};

        case (state_q)
            IDLE: begin
                if (enable) begin
                    mcand_d  = A;
                    mplier_d = {B, 1'b0};
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_q + addend;
                // Arithmetic shift brings the next overlapping triplet into [2:0].
                mplier_d = {{2{mplier_q[W]}}, mplier_q[W:2]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    p_d     = acc_d[2*W-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign P    = p_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule
